next_pc_unit: RTL
=================

Name: next_pc_unit

Overview:
- Parametrised next-PC generator for the RISC core; successor to the original next-address logic.
- Owns the architectural PC register and selects among sequential, conditional branch, absolute jump, jump-register and return targets.
- Adds a stall input, selectable sign/zero offset extension and a circular return-address stack (RAS) for call/return.
- Sits between the control unit and flag logic (inputs) and instruction fetch (pc output).

Parameters:
ADDR_W, 32, PC and target width; PC is word-addressed, increments by 1
OFFSET_W, 16, branch offset width (OFFSET_W < ADDR_W)
JMP_W, 26, absolute jump label width (JMP_W < ADDR_W)
SIGN_EXT, 1, 1 = sign-extend branch offset, 0 = zero-extend (legacy mode)
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC and RAS this cycle
zero_flag  in  1  ALU zero flag
carry_flag  in  1  ALU carry flag
msb  in  1  ALU result sign bit
overflow  in  1  ALU overflow flag
brtype  in  4  branch condition select
branch_offset  in  OFFSET_W  PC-relative branch offset
jmp_label  in  JMP_W  absolute jump label
jmp_ra  in  ADDR_W  register target for jump-register
pc_sel  in  2  0 seq/branch, 1 jump, 2 jump-register, 3 return
link  in  1  push pc+1 onto RAS on this transfer (call)
pc  out  ADDR_W  current PC (registered)
redirect  out  1  registered; 1 if the last PC update was non-sequential
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_empty  out  1  ras_count == 0 (combinational from count)
ras_full  out  1  ras_count == RAS_DEPTH
ras_underflow  out  1  one-cycle pulse: return issued with empty RAS

Behaviour:
- Reset (sync, priority over stall): pc=RESET_PC, redirect=0, ras_underflow=0, ras_count=0, stack pointer=0. Stack contents don't care.
- stall=1 (no reset): pc, RAS and ras_count hold; redirect=0 and ras_underflow=0 next cycle.
- Condition by brtype:
  - 0: always
  - 1: zero_flag; 2: ~zero_flag
  - 3: carry_flag; 4: ~carry_flag
  - 5: msb; 6: ~msb
  - 7: overflow; 8: ~overflow
  - 9-15: never taken (defined; no latching)
- seq = pc+1. ext = offset extended per SIGN_EXT. All sums are modulo 2^ADDR_W; wrap-around is silent.
- pc_sel=0: next = cond ? pc+1+ext : pc+1; redirect = cond.
- pc_sel=1: next = {pc[ADDR_W-1:JMP_W], jmp_label}; redirect=1.
- pc_sel=2: next = jmp_ra; redirect=1.
- pc_sel=3: if RAS non-empty, next = top entry, pop, redirect=1. If empty, next = jmp_ra (fallback), ras_underflow=1 for one cycle, count stays 0, redirect=1.
- Latency: one cycle; inputs sampled at edge N appear on pc after edge N.
- link=1 with pc_sel 1/2 (call): push pc+1.
  - Not full: count+1.
  - Full: overwrite oldest entry circularly; count saturates at RAS_DEPTH; no error flag.
- link=1 with pc_sel=0: push only if branch taken. Not-taken branch: link ignored.
- link=1 with pc_sel=3 (pop+push): target = old top (or jmp_ra if empty); top replaced by pc+1. Count unchanged if non-empty, becomes 1 if empty; underflow still pulses when empty.
- RAS pointer arithmetic is modulo RAS_DEPTH. After 5 pushes into a depth-4 stack, pops return the most recent 4 in LIFO order, then underflow.

Test Plan:
- Reset/sequential: assert reset 2 cycles, release, pc_sel=0, brtype=9 -> pc 0,1,2,3, redirect=0, ras_empty=1.
- Branch sign-ext: pc=0x10, brtype=1, zero_flag=1, offset=0xFFFC -> pc=0x0D, redirect=1. Same with zero_flag=0 -> pc=0x11. SIGN_EXT=0 build: zero_flag=1 -> pc=0x1000D.
- Jump/stall: pc=0xF0000010, pc_sel=1, jmp_label=0x0000123 -> pc=0xF0000123. Stall 3 cycles -> pc holds, redirect=0.
- Call/return: at pc=0x20, pc_sel=2, link=1, jmp_ra=0x100 -> pc=0x100, ras_count=1. Then pc_sel=3 -> pc=0x21, ras_count=0.
- RAS overflow/underflow (depth 4): calls from pc 0x10,0x20,0x30,0x40,0x50 -> ras_count=4, ras_full=1. Four returns -> 0x51,0x41,0x31,0x21. Fifth return with jmp_ra=0x77 -> pc=0x77, ras_underflow pulses 1 cycle.
- Reset mid-operation: ras_count=3 and stall=1, assert reset -> next cycle pc=RESET_PC, ras_count=0, redirect=0.

Source files
------------

// File: rtl/next_pc_unit_if.sv
// next_pc_unit_if: control/flag inputs and PC/RAS status outputs of the next-PC unit.
//   master: control unit / flag logic side. It drives the condition flags, the transfer
//           selects and the targets, and observes pc and the RAS status.
//   slave : next_pc_unit side.
//   Inputs to the unit : stall, zero_flag, carry_flag, msb, overflow, brtype,
//                        branch_offset, jmp_label, jmp_ra, pc_sel, link.
//   Outputs of the unit: pc, redirect, ras_count, ras_empty, ras_full, ras_underflow.
interface next_pc_unit_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned OFFSET_W  = 16,
  parameter int unsigned JMP_W     = 26,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic                stall;
  logic                zero_flag;
  logic                carry_flag;
  logic                msb;
  logic                overflow;
  logic [3:0]          brtype;
  logic [OFFSET_W-1:0] branch_offset;
  logic [JMP_W-1:0]    jmp_label;
  logic [ADDR_W-1:0]   jmp_ra;
  logic [1:0]          pc_sel;
  logic                link;

  logic [ADDR_W-1:0]   pc;
  logic                redirect;
  logic [CNT_W-1:0]    ras_count;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_underflow;

  modport master (
    output stall, zero_flag, carry_flag, msb, overflow, brtype, branch_offset,
           jmp_label, jmp_ra, pc_sel, link,
    input  pc, redirect, ras_count, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, zero_flag, carry_flag, msb, overflow, brtype, branch_offset,
           jmp_label, jmp_ra, pc_sel, link,
    output pc, redirect, ras_count, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: owns the architectural PC and chooses the next fetch address from the
// sequential, conditional-branch, absolute-jump, jump-register and return targets.
// A circular return-address stack (RAS) holds call return addresses.
// Ports:
//   clk   - clock; all state is updated on the rising edge
//   reset - synchronous, active-high; takes priority over stall
//   bus   - next_pc_unit_if.slave, which carries the control/flag inputs and the PC/RAS status
module next_pc_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       OFFSET_W  = 16,
  parameter int unsigned       JMP_W     = 26,
  parameter bit                SIGN_EXT  = 1'b1,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic            clk,
  input logic            reset,
  next_pc_unit_if.slave  bus
);
  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_JMP = 2'd1;
  localparam logic [1:0] SEL_JR  = 2'd2;
  localparam logic [1:0] SEL_RET = 2'd3;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              underflow_q, underflow_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // sp_q points at the next free slot; the top entry is at sp_q - 1.
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic              ras_we;
  logic [PTR_W-1:0]  ras_waddr;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] ext;
  logic              cond;
  logic              push;
  logic              empty;
  logic              full;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign top_idx = sp_q - PTR_W'(1);
  assign seq     = pc_q + ADDR_W'(1);

  generate
    if (SIGN_EXT) begin : g_sext
      assign ext = {{(ADDR_W-OFFSET_W){bus.branch_offset[OFFSET_W-1]}}, bus.branch_offset};
    end else begin : g_zext
      assign ext = {{(ADDR_W-OFFSET_W){1'b0}}, bus.branch_offset};
    end
  endgenerate

  // Branch condition; codes 9-15 are defined as never taken.
  always_comb begin
    cond = 1'b0;
    case (bus.brtype)
      4'd0:    cond = 1'b1;
      4'd1:    cond = bus.zero_flag;
      4'd2:    cond = ~bus.zero_flag;
      4'd3:    cond = bus.carry_flag;
      4'd4:    cond = ~bus.carry_flag;
      4'd5:    cond = bus.msb;
      4'd6:    cond = ~bus.msb;
      4'd7:    cond = bus.overflow;
      4'd8:    cond = ~bus.overflow;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    redirect_d  = 1'b0;
    underflow_d = 1'b0;
    cnt_d       = cnt_q;
    sp_d        = sp_q;
    ras_we      = 1'b0;
    ras_waddr   = sp_q;
    push        = 1'b0;
    if (!bus.stall) begin
      case (bus.pc_sel)
        SEL_SEQ: begin
          if (cond) begin
            pc_d       = seq + ext;
            redirect_d = 1'b1;
            push       = bus.link;
          end else begin
            pc_d = seq;
          end
        end
        SEL_JMP: begin
          pc_d       = {pc_q[ADDR_W-1:JMP_W], bus.jmp_label};
          redirect_d = 1'b1;
          push       = bus.link;
        end
        SEL_JR: begin
          pc_d       = bus.jmp_ra;
          redirect_d = 1'b1;
          push       = bus.link;
        end
        SEL_RET: begin
          redirect_d = 1'b1;
          if (empty) begin
            // Empty stack: fall back to the register target. A linked return
            // still pushes, so the count becomes 1.
            pc_d        = bus.jmp_ra;
            underflow_d = 1'b1;
            push        = bus.link;
          end else begin
            pc_d = ras_q[top_idx];
            if (bus.link) begin
              // Pop+push collapses into replacing the top in place.
              ras_we    = 1'b1;
              ras_waddr = top_idx;
            end else begin
              sp_d  = top_idx;
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: pc_d = seq;
      endcase

      // When the stack is full, sp_q already addresses the oldest entry, so a push
      // overwrites it and the count saturates.
      if (push) begin
        ras_we    = 1'b1;
        ras_waddr = sp_q;
        sp_d      = sp_q + PTR_W'(1);
        if (!full) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      redirect_q  <= 1'b0;
      underflow_q <= 1'b0;
      cnt_q       <= '0;
      sp_q        <= '0;
    end else begin
      pc_q        <= pc_d;
      redirect_q  <= redirect_d;
      underflow_q <= underflow_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
    end
  end

  // The stack storage is not reset; entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    if (!reset && ras_we) begin
      ras_q[ras_waddr] <= seq;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.redirect      = redirect_q;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_underflow = underflow_q;
endmodule
